// File: rtl/wfg_receive_spi.sv
// SPI target receiver: synchronizes and oversamples sclk/cs/sdi, deserializes frames into
// right-aligned words and presents them through a small FIFO on an AXI-Stream style port.
module wfg_receive_spi #(
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ctrl_en_i,
  input  logic              ctrl_cpol_i,
  input  logic              ctrl_cpha_i,
  input  logic              ctrl_cspol_i,
  input  logic              ctrl_lsbfirst_i,
  input  logic [1:0]        ctrl_size_i,
  input  logic              status_clr_i,
  input  logic              spi_sclk_i,
  input  logic              spi_cs_i,
  input  logic              spi_sdi_i,
  output logic [DATA_W-1:0] wfg_axis_tdata_o,
  output logic              wfg_axis_tvalid_o,
  input  logic              wfg_axis_tready_i,
  output logic              status_active_o,
  output logic              status_overflow_o,
  output logic              status_frame_err_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // Handshake: a beat transfers on every clk edge where tvalid and tready are both high;
  // tvalid only depends on FIFO occupancy and tdata holds while tvalid=1 and tready=0.

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizers
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sdi_sync;
  logic                   sclk_s;
  logic                   cs_s;
  logic                   sdi_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      sdi_sync  <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk_i};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_i};
      sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], spi_sdi_i};
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign sdi_s  = sdi_sync[SYNC_STAGES-1];

  // Edge detect stage; sdi and cs are registered alongside so all three stay aligned.
  logic sclk_d;
  logic rise_q;
  logic fall_q;
  logic sdi_q;
  logic cs_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_d <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      sdi_q  <= 1'b0;
      cs_q   <= 1'b0;
    end else begin
      sclk_d <= sclk_s;
      rise_q <= sclk_s & ~sclk_d;
      fall_q <= ~sclk_s & sclk_d;
      sdi_q  <= sdi_s;
      cs_q   <= cs_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame arming: cs_q only reflects the pins once the pipeline has refilled after
  // reset, and a frame may only start after cs has been seen inactive.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES:0] prime_sr;
  logic                 primed;
  logic                 armed;
  logic                 start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prime_sr <= '0;
    end else begin
      prime_sr <= {prime_sr[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign primed = prime_sr[SYNC_STAGES];

  // ---------------------------------------------------------------------------
  // Deserializer FSM
  // ---------------------------------------------------------------------------
  state_t            state;
  logic [4:0]        bitcnt;
  logic [DATA_W-1:0] shreg;
  logic              push_q;
  logic [DATA_W-1:0] push_word;
  logic              cfg_fall;
  logic              cfg_lsb;
  logic [1:0]        cfg_size;
  logic              cfg_cspol;

  logic              samp_edge;
  logic [4:0]        msb_idx;
  logic              last_bit;
  logic [DATA_W-1:0] shifted;
  logic [4:0]        cnt_next;
  logic              cs_act_cfg;
  logic              frame_err_set;

  always_comb begin
    samp_edge     = (state == SHIFT) && (cfg_fall ? fall_q : rise_q);
    msb_idx       = {cfg_size, 3'b111};
    last_bit      = (bitcnt == msb_idx);
    if (cfg_lsb) begin
      shifted = (shreg >> 1) | ({{(DATA_W-1){1'b0}}, sdi_q} << msb_idx);
    end else begin
      shifted = {shreg[DATA_W-2:0], sdi_q};
    end
    cnt_next = bitcnt;
    if (samp_edge) begin
      cnt_next = last_bit ? 5'd0 : bitcnt + 5'd1;
    end
    cs_act_cfg    = (cs_q == cfg_cspol);
    start         = ctrl_en_i && (state == IDLE) && armed && (cs_q == ctrl_cspol_i);
    // The sampling edge is folded into cnt_next first, so a word completed in the
    // same cycle as cs deassert does not count as a partial word.
    frame_err_set = ctrl_en_i && (state == SHIFT) && !cs_act_cfg && (cnt_next != 5'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b0;
    end else if (start) begin
      armed <= 1'b0;
    end else if (primed && (cs_q != ctrl_cspol_i)) begin
      armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bitcnt    <= 5'd0;
      shreg     <= '0;
      push_q    <= 1'b0;
      push_word <= '0;
      cfg_fall  <= 1'b0;
      cfg_lsb   <= 1'b0;
      cfg_size  <= 2'd0;
      cfg_cspol <= 1'b0;
    end else begin
      push_q <= 1'b0;
      if (!ctrl_en_i) begin
        state  <= IDLE;
        bitcnt <= 5'd0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state     <= SHIFT;
              bitcnt    <= 5'd0;
              shreg     <= '0;
              cfg_fall  <= ctrl_cpol_i ^ ctrl_cpha_i;
              cfg_lsb   <= ctrl_lsbfirst_i;
              cfg_size  <= ctrl_size_i;
              cfg_cspol <= ctrl_cspol_i;
            end
          end
          SHIFT: begin
            if (samp_edge) begin
              if (last_bit) begin
                push_q    <= 1'b1;
                push_word <= shifted;
                shreg     <= '0;
              end else begin
                shreg <= shifted;
              end
            end
            bitcnt <= cnt_next;
            if (!cs_act_cfg) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign status_active_o = (state == SHIFT);

  // ---------------------------------------------------------------------------
  // Output FIFO (pointers carry one wrap bit to tell full from empty)
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wptr;
  logic [AW:0]       rptr;
  logic              empty;
  logic              full;
  logic              pop;
  logic              do_push;
  logic              overflow_set;

  assign empty        = (wptr == rptr);
  assign full         = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop          = wfg_axis_tvalid_o && wfg_axis_tready_i;
  assign do_push      = ctrl_en_i && push_q && (!full || pop);
  assign overflow_set = ctrl_en_i && push_q && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (!ctrl_en_i) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + (AW+1)'(1);
      end
      if (pop) begin
        rptr <= rptr + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr[AW-1:0]] <= push_word;
    end
  end

  assign wfg_axis_tvalid_o = ctrl_en_i && !empty;
  assign wfg_axis_tdata_o  = wfg_axis_tvalid_o ? mem[rptr[AW-1:0]] : '0;

  // ---------------------------------------------------------------------------
  // Sticky status flags: a set wins over a clear in the same cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_overflow_o  <= 1'b0;
      status_frame_err_o <= 1'b0;
    end else begin
      if (overflow_set) begin
        status_overflow_o <= 1'b1;
      end else if (status_clr_i) begin
        status_overflow_o <= 1'b0;
      end
      if (frame_err_set) begin
        status_frame_err_o <= 1'b1;
      end else if (status_clr_i) begin
        status_frame_err_o <= 1'b0;
      end
    end
  end

endmodule
